// File: rtl/shift_defs.sv
// Shared definitions for the universal shift register: mode encodings used by
// every block that drives or decodes the mode bus.
package shift_defs;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle of the universal shift register; master drives the
// operation, slave (the register) returns contents and the word strobe.
interface shift_reg_univ_if #(
   parameter int WIDTH = 4
);
   import shift_defs::*;
   localparam int CW = $clog2(WIDTH);

   logic          en;
   mode_t         mode;
   logic          serial_in;
   logic          serial_in_l;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic          serial_out;
   logic          serial_out_l;
   logic [CW-1:0] bit_cnt;
   logic          word_done;

   modport master (
      output en, mode, serial_in, serial_in_l, d,
      input  q, serial_out, serial_out_l, bit_cnt, word_done
   );

   modport slave (
      input  en, mode, serial_in, serial_in_l, d,
      output q, serial_out, serial_out_l, bit_cnt, word_done
   );
endinterface

// File: rtl/shift_bit_counter.sv
// Counts shifts modulo WIDTH and emits a registered strobe on the edge that
// completes a word. A clear (load) restarts the word without a strobe.
module shift_bit_counter #(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] bit_cnt,
   output logic          wrap_pulse
);
   // Explicit wrap so non-power-of-2 widths never reach WIDTH..2**CW-1.
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         wrap_pulse <= 1'b0;
      end else if (clr) begin
         bit_cnt    <= '0;
         wrap_pulse <= 1'b0;
      end else if (inc) begin
         if (bit_cnt == LAST) begin
            bit_cnt    <= '0;
            wrap_pulse <= 1'b1;
         end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            wrap_pulse <= 1'b0;
         end
      end else begin
         wrap_pulse <= 1'b0;
      end
   end
endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with a shift counter that strobes word_done every WIDTH shifts.
module shift_reg_univ
   import shift_defs::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic clk,
   input  logic rst_n,
   shift_reg_univ_if.slave bus
);
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             shift;
   logic             load;

   // en gates every mode, so a disabled cycle is a hold for both data and counter.
   always_comb begin
      q_nxt = q_r;
      shift = 1'b0;
      load  = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            MODE_SHR: begin
               q_nxt = {bus.serial_in, q_r[WIDTH-1:1]};
               shift = 1'b1;
            end
            MODE_SHL: begin
               q_nxt = {q_r[WIDTH-2:0], bus.serial_in_l};
               shift = 1'b1;
            end
            MODE_LOAD: begin
               q_nxt = bus.d;
               load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_r <= RESET_VAL;
      else        q_r <= q_nxt;
   end

   assign bus.q            = q_r;
   assign bus.serial_out   = q_r[0];
   assign bus.serial_out_l = q_r[WIDTH-1];

   shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (shift),
      .clr        (load),
      .bit_cnt    (bus.bit_cnt),
      .wrap_pulse (bus.word_done)
   );
endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: three widths (4, 8, 5) driven with common stimulus
// and checked against an arithmetic reference model, a vector table and corner sequences.
module tb_shift_reg_univ;
   import shift_defs::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   shift_reg_univ_if #(.WIDTH(4)) b4 ();
   shift_reg_univ_if #(.WIDTH(8)) b8 ();
   shift_reg_univ_if #(.WIDTH(5)) b5 ();

   shift_reg_univ #(.WIDTH(4), .RESET_VAL(4'hA)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
   shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   shift_reg_univ #(.WIDTH(5), .RESET_VAL(5'h00)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

   int checks = 0;
   int passes = 0;

   int wid[3];
   int rv[3];
   int mq[3];
   int mc[3];
   int md[3];

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic void mreset();
      for (int i = 0; i < 3; i++) begin
         mq[i] = rv[i];
         mc[i] = 0;
         md[i] = 0;
      end
   endfunction

   // Reference: register as an integer, counter as shifts-mod-width.
   function automatic void madv(bit e, bit [1:0] m, bit si, bit sil, int dd);
      for (int i = 0; i < 3; i++) begin
         int w    = wid[i];
         int mask = (1 << w) - 1;
         md[i] = 0;
         if (e && (m == MODE_SHR || m == MODE_SHL)) begin
            if (m == MODE_SHR) mq[i] = (mq[i] >> 1) | (int'(si) << (w - 1));
            else               mq[i] = ((mq[i] << 1) | int'(sil)) & mask;
            mc[i] = (mc[i] + 1) % w;
            md[i] = (mc[i] == 0) ? 1 : 0;
         end else if (e && m == MODE_LOAD) begin
            mq[i] = dd & mask;
            mc[i] = 0;
         end
      end
   endfunction

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         int aq, ac, ad, as, al;
         case (i)
            0: begin aq = 32'(b4.q); ac = 32'(b4.bit_cnt); ad = 32'(b4.word_done);
                     as = 32'(b4.serial_out); al = 32'(b4.serial_out_l); end
            1: begin aq = 32'(b8.q); ac = 32'(b8.bit_cnt); ad = 32'(b8.word_done);
                     as = 32'(b8.serial_out); al = 32'(b8.serial_out_l); end
            default: begin aq = 32'(b5.q); ac = 32'(b5.bit_cnt); ad = 32'(b5.word_done);
                     as = 32'(b5.serial_out); al = 32'(b5.serial_out_l); end
         endcase
         chk($sformatf("w%0d_q", wid[i]), aq, mq[i]);
         chk($sformatf("w%0d_bit_cnt", wid[i]), ac, mc[i]);
         chk($sformatf("w%0d_word_done", wid[i]), ad, md[i]);
         chk($sformatf("w%0d_serial_out", wid[i]), as, mq[i] & 1);
         chk($sformatf("w%0d_serial_out_l", wid[i]), al, (mq[i] >> (wid[i] - 1)) & 1);
      end
   endtask

   task automatic drive(bit e, bit [1:0] m, bit si, bit sil, int dd);
      b4.en = e; b4.mode = m; b4.serial_in = si; b4.serial_in_l = sil; b4.d = dd[3:0];
      b8.en = e; b8.mode = m; b8.serial_in = si; b8.serial_in_l = sil; b8.d = dd[7:0];
      b5.en = e; b5.mode = m; b5.serial_in = si; b5.serial_in_l = sil; b5.d = dd[4:0];
   endtask

   task automatic step(bit e, bit [1:0] m, bit si, bit sil, int dd);
      drive(e, m, si, sil, dd);
      @(posedge clk);
      madv(e, m, si, sil, dd);
      #1;
      compare_all();
   endtask

   typedef struct {
      bit       e;
      bit [1:0] m;
      bit       si;
      bit       sil;
      int       dd;
      int       eq;
      int       ec;
      int       ed;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int strobes, last_done, held_q, maxc, first_idx, second_idx;
      bit seq8[8];

      wid = '{4, 8, 5};
      rv  = '{10, 0, 0};
      seq8 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      // W4 vectors starting from reset (q=A): SIPO 1,0,1,1 then mixed ops.
      tbl[0]  = '{1, MODE_LOAD, 0, 0, 0, 4'h0, 0, 0};
      tbl[1]  = '{1, MODE_SHR,  1, 0, 0, 4'b1000, 1, 0};
      tbl[2]  = '{1, MODE_SHR,  0, 0, 0, 4'b0100, 2, 0};
      tbl[3]  = '{1, MODE_SHR,  1, 0, 0, 4'b1010, 3, 0};
      tbl[4]  = '{1, MODE_SHR,  1, 0, 0, 4'b1101, 0, 1};
      tbl[5]  = '{1, MODE_HOLD, 0, 1, 7, 4'b1101, 0, 0};
      tbl[6]  = '{1, MODE_SHL,  1, 0, 0, 4'b1010, 1, 0};
      tbl[7]  = '{0, MODE_SHL,  1, 1, 0, 4'b1010, 1, 0};
      tbl[8]  = '{1, MODE_SHR,  0, 1, 0, 4'b0101, 2, 0};
      tbl[9]  = '{1, MODE_LOAD, 1, 1, 9, 4'b1001, 0, 0};
      tbl[10] = '{1, MODE_SHL,  0, 1, 0, 4'b0011, 1, 0};
      tbl[11] = '{1, MODE_SHL,  0, 1, 0, 4'b0111, 2, 0};
      tbl[12] = '{1, MODE_SHL,  0, 0, 0, 4'b1110, 3, 0};
      tbl[13] = '{1, MODE_SHR,  1, 0, 0, 4'b1111, 0, 1};
      tbl[14] = '{1, MODE_LOAD, 0, 0, 3, 4'b0011, 0, 0};

      rst_n = 1'b0;
      drive(0, MODE_HOLD, 0, 0, 0);
      #12;
      chk("reset_q4", 32'(b4.q), 32'hA);
      chk("reset_cnt4", 32'(b4.bit_cnt), 0);
      chk("reset_done4", 32'(b4.word_done), 0);
      chk("reset_q8", 32'(b8.q), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mreset();

      foreach (tbl[k]) begin
         step(tbl[k].e, tbl[k].m, tbl[k].si, tbl[k].sil, tbl[k].dd);
         chk($sformatf("tbl%0d_q4", k), 32'(b4.q), tbl[k].eq);
         chk($sformatf("tbl%0d_cnt4", k), 32'(b4.bit_cnt), tbl[k].ec);
         chk($sformatf("tbl%0d_done4", k), 32'(b4.word_done), tbl[k].ed);
      end

      // Asynchronous reset mid-cycle with a partial word in flight.
      step(1, MODE_SHR, 1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_q4", 32'(b4.q), 32'hA);
      chk("async_rst_cnt4", 32'(b4.bit_cnt), 0);
      chk("async_rst_done4", 32'(b4.word_done), 0);
      mreset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, MODE_HOLD, 0, 0, 0);

      // PISO left on W8: load C5, shift out MSB first.
      step(1, MODE_LOAD, 0, 0, 32'hC5);
      strobes = 0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("piso_bit%0d", k), 32'(b8.serial_out_l), 32'(seq8[k]));
         step(1, MODE_SHL, 0, 0, 0);
         strobes += 32'(b8.word_done);
      end
      chk("piso_final_q8", 32'(b8.q), 0);
      chk("piso_strobes8", strobes, 1);

      // Enable hold on W4: 2 shifts, 3 disabled cycles, 2 shifts.
      step(1, MODE_LOAD, 0, 0, 32'h6);
      strobes = 0;
      step(1, MODE_SHR, 1, 0, 0); strobes += 32'(b4.word_done);
      step(1, MODE_SHR, 0, 0, 0); strobes += 32'(b4.word_done);
      held_q = 32'(b4.q);
      for (int k = 0; k < 3; k++) begin
         step(0, MODE_SHR, 1, 1, 32'hF);
         strobes += 32'(b4.word_done);
         chk($sformatf("hold%0d_q4", k), 32'(b4.q), held_q);
      end
      step(1, MODE_SHR, 1, 0, 0); strobes += 32'(b4.word_done);
      step(1, MODE_SHR, 1, 0, 0); last_done = 32'(b4.word_done); strobes += last_done;
      chk("hold_done_after4", last_done, 1);
      chk("hold_strobes4", strobes, 1);

      // Load mid-word on W4 discards the partial count.
      step(1, MODE_LOAD, 0, 0, 0);
      strobes = 0;
      for (int k = 0; k < 3; k++) begin
         step(1, MODE_SHR, 1, 0, 0);
         strobes += 32'(b4.word_done);
      end
      step(1, MODE_LOAD, 0, 0, 9);
      chk("midload_q4", 32'(b4.q), 9);
      chk("midload_cnt4", 32'(b4.bit_cnt), 0);
      chk("midload_done4", 32'(b4.word_done), 0);
      for (int k = 0; k < 4; k++) begin
         step(1, MODE_SHL, 0, 0, 0);
         strobes += 32'(b4.word_done);
         if (k == 3) chk("midload_done_4th", 32'(b4.word_done), 1);
      end
      chk("midload_strobes4", strobes, 1);

      // Non-power-of-2 W5: 10 continuous shifts -> strobes after 5 and 10.
      step(1, MODE_LOAD, 0, 0, 0);
      strobes = 0; maxc = 0; first_idx = 0; second_idx = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1, (k % 2 != 0) ? MODE_SHR : MODE_SHL, 1, 0, 0);
         if (32'(b5.bit_cnt) > maxc) maxc = 32'(b5.bit_cnt);
         if (b5.word_done) begin
            strobes++;
            if (strobes == 1) first_idx = k;
            else if (strobes == 2) second_idx = k;
         end
      end
      chk("w5_strobes", strobes, 2);
      chk("w5_first_strobe", first_idx, 5);
      chk("w5_second_strobe", second_idx, 10);
      chk("w5_cnt_le4", (maxc <= 4) ? 1 : 0, 1);

      // Randomised traffic, shift-heavy to exercise wraps.
      for (int k = 0; k < 300; k++) begin
         bit [1:0] m;
         int r = $urandom_range(0, 9);
         m = (r < 4) ? MODE_SHR : (r < 8) ? MODE_SHL : (r == 8) ? MODE_LOAD : MODE_HOLD;
         step(($urandom_range(0, 7) != 0), m, 1'($urandom), 1'($urandom), int'($urandom));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, successor to the 4-bit serial-in/parallel-out register. Width is configurable; the block supports hold, shift right, shift left and parallel load. A shift counter raises a one-cycle `word_done` strobe after every WIDTH shifts. It is the serialiser/deserialiser primitive for the datapath exercises and serial links in the practical series.

## Interface
Parameters:
- `WIDTH`, 4: register width in bits; legal range 2..32.
- `RESET_VAL`, 0: value loaded into `q` on reset, WIDTH bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: clock enable; 0 forces hold regardless of `mode`.
- `mode` input 2: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `serial_in` input 1: bit entering the MSB on a right shift.
- `serial_in_l` input 1: bit entering the LSB on a left shift.
- `d` input WIDTH: parallel load data.
- `q` output WIDTH: parallel register contents.
- `serial_out` output 1: equals `q[0]` (right-shift output), combinational from `q`.
- `serial_out_l` output 1: equals `q[WIDTH-1]` (left-shift output), combinational from `q`.
- `bit_cnt` output $clog2(WIDTH): number of shifts since the last load, reset or wrap.
- `word_done` output 1: registered one-cycle strobe.

## Operation
- Reset, asynchronous on `rst_n`=0: `q`=RESET_VAL, `bit_cnt`=0, `word_done`=0. The reset holds while `rst_n` is low and releases synchronously on the next edge after `rst_n`=1. A reset mid-word discards the partial word with no strobe.
- `en`=0 or mode 00: `q` and `bit_cnt` hold, and `word_done`=0 on that edge.
- Mode 01, shift right: `q <= {serial_in, q[WIDTH-1:1]}`.
- Mode 10, shift left: `q <= {q[WIDTH-2:0], serial_in_l}`.
- Mode 11, parallel load: `q <= d`, `bit_cnt <= 0`, `word_done <= 0`.
- Shift counting:
  - Each shift in either direction increments `bit_cnt`.
  - When `bit_cnt`==WIDTH-1 and a shift occurs, `bit_cnt` wraps to 0 and `word_done <= 1` on the same edge.
  - Any other edge drives `word_done <= 0`.
- Mixing directions within a word is legal. The counter counts shifts, not direction.
- `bit_cnt` arithmetic is unsigned modulo WIDTH. For non-power-of-2 WIDTH, the wrap is explicit at WIDTH-1, not natural overflow.
- Counter FSM, implicit in `bit_cnt`:
  - IDLE/COUNT(k) -> COUNT(k+1) on shift.
  - COUNT(WIDTH-1) -> COUNT(0) with strobe.
  - Any state -> COUNT(0) on load or reset.

## Timing
- Latency: `q` reflects an operation one edge after it is sampled; `serial_out`/`serial_out_l` follow `q` with zero added cycles.
- `word_done` is high for exactly the cycle following the edge that performs the WIDTH-th shift, and never for two consecutive cycles unless WIDTH shifts occur in consecutive cycles, which is impossible for WIDTH≥2.
- Back-to-back words: continuous shifting strobes every WIDTH cycles with no bubble.
- A load on the cycle after a strobe is legal; the strobe still lasts its full cycle.
- Inputs must be stable around the rising edge of `clk`. There is no handshake; `en` is the only flow control.

## Structure
- Shared package/header `shift_defs`: mode constants `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11. Every block that drives `mode` uses these.
- Sub-module `shift_bit_counter`:
  - Parameter WIDTH.
  - Inputs `clk`, `rst_n`, `inc`, `clr`.
  - Outputs `bit_cnt`, `wrap_pulse`.
  - `wrap_pulse` is registered and becomes `word_done`.
- The top level holds the data register and the mode decode.

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-cycle with WIDTH=4 and RESET_VAL=4'hA -> `q`=4'hA immediately, `bit_cnt`=0, `word_done`=0.
- SIPO right, WIDTH=4 from q=0: `serial_in` 1,0,1,1 over 4 cycles in mode 01 -> `q`=4'b1101, `word_done` high exactly one cycle after the 4th edge, `bit_cnt`=0.
- PISO left, WIDTH=8: load `d`=8'hC5, then 8 left shifts with `serial_in_l`=0 -> `serial_out_l` sequence 1,1,0,0,0,1,0,1, final `q`=8'h00, one `word_done`.
- Enable/hold: after 2 right shifts, hold 3 cycles with `en`=0, then 2 more shifts -> `word_done` fires only after the 4th shift (WIDTH=4). `q` is unchanged during the hold.
- Load mid-word: WIDTH=4, 3 shifts then load 4'h9 -> `q`=4'h9, `bit_cnt`=0, no strobe. Strobe appears only after 4 further shifts.
- Non-power-of-2: WIDTH=5 with 10 continuous shifts -> `word_done` pulses after shifts 5 and 10. `bit_cnt` never exceeds 4.
